// File: rtl/fifo_stream_reader.sv
// Read-side master for the sync FIFO: issues rd_en, captures the 1-cycle-late data into a
// 2-entry buffer and presents it as a valid/ready stream. Optional counters: FIFO_RD_STATS_EN.
module fifo_stream_reader #(
   parameter int FIFO_WIDTH = 16
`ifdef FIFO_RD_STATS_EN
   , parameter int STAT_W = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   output logic                  rd_en,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic [1:0]            dbg_state
`ifdef FIFO_RD_STATS_EN
   , input  logic                stats_clr,
   output logic [STAT_W-1:0]     words_out,
   output logic                  underflow_err
`endif
);

   // Stream handshake: a word moves when m_valid & m_ready are both high at a rising edge;
   // m_data/m_valid never change while m_valid & !m_ready.
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_e;

   buf_state_e            state_q;
   logic [FIFO_WIDTH-1:0] head_q;
   logic [FIFO_WIDTH-1:0] tail_q;
   logic                  inflight_q;

   logic       pop;
   logic       capture;
   logic       drop;
   logic [1:0] occ;
   logic [2:0] slots_used;

   assign occ     = state_q;
   assign pop     = m_valid & m_ready;
   assign capture = inflight_q & ~fifo_underflow;
   assign drop    = inflight_q & fifo_underflow;

   // Buffered words plus the word in flight, minus the one leaving this cycle.
   assign slots_used = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
   assign rd_en      = rst_n & en & ~fifo_empty & (slots_used < 3'd2);

   assign m_valid   = (state_q != BUF_EMPTY);
   assign m_data    = head_q;
   assign busy      = inflight_q | (state_q != BUF_EMPTY);
   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BUF_EMPTY;
         head_q     <= '0;
         tail_q     <= '0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= rd_en;
         case (state_q)
            BUF_EMPTY: begin
               if (capture) begin
                  head_q  <= fifo_data_out;
                  state_q <= BUF_ONE;
               end
            end
            BUF_ONE: begin
               if (capture && pop) begin
                  head_q <= fifo_data_out;
               end else if (capture) begin
                  tail_q  <= fifo_data_out;
                  state_q <= BUF_TWO;
               end else if (pop) begin
                  state_q <= BUF_EMPTY;
               end
            end
            BUF_TWO: begin
               // The read gate keeps occupancy plus in-flight at two, so no capture lands here.
               if (pop) begin
                  head_q  <= tail_q;
                  state_q <= BUF_ONE;
                  if (capture) begin
                     tail_q  <= fifo_data_out;
                     state_q <= BUF_TWO;
                  end
               end
            end
            default: state_q <= BUF_EMPTY;
         endcase
      end
   end

   a_no_capture_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(state_q == BUF_TWO && capture));

`ifdef FIFO_RD_STATS_EN
   logic [STAT_W-1:0] words_q;
   logic [STAT_W-1:0] words_d;
   logic              uf_err_q;
   logic              uf_err_d;

   always_comb begin
      words_d  = words_q;
      uf_err_d = uf_err_q;
      if (stats_clr) begin
         words_d  = '0;
         uf_err_d = 1'b0;
      end else begin
         if (pop && (words_q != {STAT_W{1'b1}})) words_d = words_q + 1'b1;
         if (drop) uf_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         words_q  <= '0;
         uf_err_q <= 1'b0;
      end else begin
         words_q  <= words_d;
         uf_err_q <= uf_err_d;
      end
   end

   assign words_out     = words_q;
   assign underflow_err = uf_err_q;
`else
   logic unused_drop;
   assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a queue-based FIFO model answers rd_en one cycle late.
module tb_fifo_stream_reader;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         rd_en;
  logic [W-1:0] fifo_data_out = '0;
  logic         fifo_empty = 1'b1;
  logic         fifo_underflow = 1'b0;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         busy;
  logic [1:0]   dbg_state;
`ifdef FIFO_RD_STATS_EN
  logic         stats_clr = 1'b0;
  logic [15:0]  words_out;
  logic         underflow_err;
`endif

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           xfer_at_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           rd_cnt = 0;
  logic         force_uf = 1'b0;

  fifo_stream_reader #(.FIFO_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rd_en(rd_en),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .dbg_state(dbg_state)
`ifdef FIFO_RD_STATS_EN
    , .stats_clr(stats_clr), .words_out(words_out), .underflow_err(underflow_err)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // One clock cycle: sample handshakes before the edge, answer reads after it.
  task automatic tick();
    logic rd;
    #1;
    rd = rd_en;
    if (rd) rd_cnt++;
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      xfer_at_q.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rd) begin
      if (fifo_q.size() > 0) begin
        fifo_data_out = fifo_q.pop_front();
        fifo_underflow = force_uf;
      end else begin
        fifo_underflow = 1'b1;
      end
    end else begin
      fifo_underflow = 1'b0;
    end
    fifo_empty = (fifo_q.size() == 0);
    #1;
  endtask

  // driver: push consecutive words into the FIFO model and the expected queue
  task automatic load(input logic [W-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(first + W'(i));
      exp_q.push_back(first + W'(i));
    end
    fifo_empty = (fifo_q.size() == 0);
    #1;
  endtask

  task automatic clear_sb();
    got_q.delete();
    exp_q.delete();
    xfer_at_q.delete();
    rd_cnt = 0;
  endtask

  task automatic test_reset();
    clear_sb();
    rst_n = 1'b0; en = 1'b1; m_ready = 1'b0;
    load(16'h0D01, 3);
    repeat (2) tick();
    n_cmp++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rd_en: got %b want 0", rd_en); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 16'h0000) begin n_err++; $display("FAIL rst_m_data: got %h want 0000", m_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (rd_cnt !== 0) begin n_err++; $display("FAIL rst_no_reads: got %0d want 0", rd_cnt); end
`ifdef FIFO_RD_STATS_EN
    n_cmp++; if (words_out !== 16'd0) begin n_err++; $display("FAIL rst_words: got %0d want 0", words_out); end
`endif
    rst_n = 1'b1;
    #1;
    n_cmp++; if (rd_en !== 1'b1) begin n_err++; $display("FAIL rst_release_rd_en: got %b want 1", rd_en); end
    m_ready = 1'b1;
    repeat (6) tick();
    n_cmp++; if (got_q.size() !== 3) begin n_err++; $display("FAIL rst_drain_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rst_drain[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stream();
    clear_sb();
    m_ready = 1'b1;
    load(16'h0001, 8);
    n_cmp++; if (rd_en !== 1'b1) begin n_err++; $display("FAIL stream_first_rd: got %b want 1", rd_en); end
    tick();
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL stream_lat1_valid: got %b want 0", m_valid); end
    tick();
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 16'h0001) begin n_err++; $display("FAIL stream_lat2: got v=%b d=%h want v=1 d=0001", m_valid, m_data); end
    repeat (10) tick();
    n_cmp++; if (got_q.size() !== 8) begin n_err++; $display("FAIL stream_count: got %0d want 8", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stream_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    if (xfer_at_q.size() == 8) begin
      n_cmp++; if (xfer_at_q[7] - xfer_at_q[0] !== 7) begin n_err++; $display("FAIL stream_rate: span %0d want 7", xfer_at_q[7] - xfer_at_q[0]); end
    end
    n_cmp++; if (rd_cnt !== 8) begin n_err++; $display("FAIL stream_reads: got %0d want 8", rd_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stream_idle: got %b want 0", busy); end
`ifdef FIFO_RD_STATS_EN
    n_cmp++; if (words_out !== 16'd11) begin n_err++; $display("FAIL stream_words: got %0d want 11", words_out); end
`endif
  endtask

  task automatic test_backpressure();
    clear_sb();
    m_ready = 1'b0;
    load(16'hA000, 8);
    repeat (6) tick();
    n_cmp++; if (rd_cnt !== 2) begin n_err++; $display("FAIL bp_reads: got %0d want 2", rd_cnt); end
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 16'hA000) begin n_err++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=a000", m_valid, m_data); end
    n_cmp++; if (dbg_state !== 2'd2) begin n_err++; $display("FAIL bp_state: got %0d want 2", dbg_state); end
    n_cmp++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL bp_rd_en: got %b want 0", rd_en); end
    m_ready = 1'b1;
    repeat (14) tick();
    n_cmp++; if (got_q.size() !== 8) begin n_err++; $display("FAIL bp_count: got %0d want 8", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (rd_cnt !== 8) begin n_err++; $display("FAIL bp_total_reads: got %0d want 8", rd_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_idle: got %b want 0", busy); end
  endtask

  task automatic test_empty_resume();
    clear_sb();
    m_ready = 1'b1;
    load(16'h5A5A, 1);
    repeat (5) tick();
    n_cmp++; if (rd_cnt !== 1) begin n_err++; $display("FAIL empty_reads: got %0d want 1", rd_cnt); end
    n_cmp++; if (got_q.size() !== 1 || got_q[0] !== 16'h5A5A) begin n_err++; $display("FAIL empty_word: got n=%0d want one 5a5a", got_q.size()); end
    repeat (3) tick();
    n_cmp++; if (rd_en !== 1'b0 || rd_cnt !== 1) begin n_err++; $display("FAIL empty_idle: got rd_en=%b reads=%0d want 0/1", rd_en, rd_cnt); end
    load(16'h1234, 1);
    n_cmp++; if (rd_en !== 1'b1) begin n_err++; $display("FAIL empty_refill_rd: got %b want 1", rd_en); end
    repeat (5) tick();
    n_cmp++; if (rd_cnt !== 2) begin n_err++; $display("FAIL empty_resume_reads: got %0d want 2", rd_cnt); end
    n_cmp++; if (got_q.size() !== 2 || got_q[got_q.size()-1] !== 16'h1234) begin n_err++; $display("FAIL empty_resume_word: got n=%0d want 2 ending 1234", got_q.size()); end
  endtask

  task automatic test_underflow();
    clear_sb();
    m_ready = 1'b1;
    load(16'h0B01, 2);
    void'(exp_q.pop_front());
    force_uf = 1'b1;
    tick();
    force_uf = 1'b0;
    tick();
    n_cmp++; if (m_valid !== 1'b0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL uf_no_capture: got v=%b st=%0d want 0/0", m_valid, dbg_state); end
`ifdef FIFO_RD_STATS_EN
    n_cmp++; if (underflow_err !== 1'b1) begin n_err++; $display("FAIL uf_err_set: got %b want 1", underflow_err); end
`endif
    tick();
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 16'h0B02) begin n_err++; $display("FAIL uf_next_word: got v=%b d=%h want 1/0b02", m_valid, m_data); end
    repeat (3) tick();
    n_cmp++; if (got_q.size() !== 1) begin n_err++; $display("FAIL uf_count: got %0d want 1", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL uf_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (rd_cnt !== 2) begin n_err++; $display("FAIL uf_no_reissue: got %0d want 2", rd_cnt); end
`ifdef FIFO_RD_STATS_EN
    n_cmp++; if (underflow_err !== 1'b1 || words_out !== 16'd22) begin n_err++; $display("FAIL uf_sticky: got err=%b words=%0d want 1/22", underflow_err, words_out); end
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    n_cmp++; if (underflow_err !== 1'b0 || words_out !== 16'd0) begin n_err++; $display("FAIL uf_clr: got err=%b words=%0d want 0/0", underflow_err, words_out); end
`endif
  endtask

  task automatic test_en_drop_reset();
    clear_sb();
    m_ready = 1'b0; en = 1'b1;
    load(16'hC000, 6);
    repeat (2) tick();
    en = 1'b0;
    #1;
    n_cmp++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL en_low_rd: got %b want 0", rd_en); end
    tick();
    n_cmp++; if (dbg_state !== 2'd2 || busy !== 1'b1) begin n_err++; $display("FAIL en_low_inflight: got st=%0d busy=%b want 2/1", dbg_state, busy); end
    m_ready = 1'b1;
    repeat (4) tick();
    n_cmp++; if (got_q.size() !== 2 || got_q[0] !== 16'hC000 || got_q[got_q.size()-1] !== 16'hC001) begin n_err++; $display("FAIL en_low_drain: got n=%0d want c000,c001", got_q.size()); end
    n_cmp++; if (busy !== 1'b0 || rd_cnt !== 2) begin n_err++; $display("FAIL en_low_idle: got busy=%b reads=%0d want 0/2", busy, rd_cnt); end
    repeat (2) void'(exp_q.pop_front());
    got_q.delete();
    en = 1'b1; m_ready = 1'b0;
    repeat (2) tick();
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 16'hC002) begin n_err++; $display("FAIL mid_buffered: got v=%b d=%h want 1/c002", m_valid, m_data); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (m_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0 || m_data !== 16'h0000) begin n_err++; $display("FAIL mid_reset: got v=%b busy=%b rd=%b d=%h want 0/0/0/0000", m_valid, busy, rd_en, m_data); end
`ifdef FIFO_RD_STATS_EN
    n_cmp++; if (words_out !== 16'd0) begin n_err++; $display("FAIL mid_reset_words: got %0d want 0", words_out); end
`endif
    tick();
    rst_n = 1'b1; m_ready = 1'b1;
    repeat (2) void'(exp_q.pop_front());
    repeat (6) tick();
    n_cmp++; if (got_q.size() !== 2) begin n_err++; $display("FAIL post_reset_count: got %0d want 2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL post_reset_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_resume();
    test_underflow();
    test_en_drop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
